// File: rtl/pulse_period_meter.sv
// ---------------------------------------------------------------------------
// pulse_period_meter
//
// Receive-side companion to the periodic pulse generator. It samples a
// single-cycle pulse train and measures the number of cycles between
// consecutive pulses. The result is reported as (interval - 1), which is the
// generator's enable_val encoding. After LOCK_COUNT identical consecutive
// measurements it declares lock. It also flags period changes (mismatch) and
// missing pulses (timeout).
//
// Parameters
//   WIDTH        width of the measured period; intervals 1 .. 2^WIDTH cycles
//   LOCK_COUNT   identical consecutive measurements needed for lock (>= 1)
//
// Ports
//   clk           system clock, rising edge
//   rst           synchronous active-high reset
//   pulse_in      pulse train; every high cycle is one pulse event
//   period_out    last measured interval minus 1 (registered)
//   period_valid  one-cycle strobe, period_out updated this cycle
//   locked        high while LOCK_COUNT consecutive measurements agree
//   mismatch      one-cycle strobe, a measurement differed while tracking
//   timeout       one-cycle strobe, no pulse for more than 2^WIDTH cycles
// ---------------------------------------------------------------------------
module pulse_period_meter #(
   parameter int WIDTH      = 4,
   parameter int LOCK_COUNT = 3
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             pulse_in,
   output logic [WIDTH-1:0] period_out,
   output logic             period_valid,
   output logic             locked,
   output logic             mismatch,
   output logic             timeout
);

   // The match counter only has to reach LOCK_COUNT, where it saturates.
   localparam int MCW = (LOCK_COUNT < 1) ? 1 : $clog2(LOCK_COUNT + 1);
   localparam logic [MCW-1:0] LOCK_MAX      = MCW'(LOCK_COUNT);
   localparam logic [MCW-1:0] MATCH_ONE     = MCW'(1);
   localparam logic           LOCK_ON_FIRST = (LOCK_COUNT == 1);

   typedef enum logic [1:0] {
      IDLE,
      ARMED,
      TRACK
   } state_t;

   state_t           state_q, state_d;
   logic [WIDTH-1:0] gap_cnt_q, gap_cnt_d;
   logic [WIDTH-1:0] period_q, period_d;
   logic [MCW-1:0]   match_cnt_q, match_cnt_d;
   logic             valid_q, valid_d;
   logic             locked_q, locked_d;
   logic             mismatch_q, mismatch_d;
   logic             timeout_q, timeout_d;

   logic             gap_full;
   logic [MCW-1:0]   match_inc;

   // The gap counter is never allowed to wrap: reaching all ones without a
   // pulse is the timeout condition, which pre-empts the increment.
   assign gap_full  = (gap_cnt_q == '1);
   assign match_inc = (match_cnt_q >= LOCK_MAX) ? match_cnt_q : match_cnt_q + MATCH_ONE;

   // State register.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // Next-state logic. A pulse always wins over the timeout condition, so an
   // interval of exactly 2^WIDTH cycles is measured rather than timed out.
   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE: begin
            if (pulse_in) begin
               state_d = ARMED;
            end
         end
         ARMED: begin
            if (pulse_in) begin
               state_d = TRACK;
            end else if (gap_full) begin
               state_d = IDLE;
            end
         end
         TRACK: begin
            if (!pulse_in && gap_full) begin
               state_d = IDLE;
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   // Datapath and output logic. The arming pulse only starts the gap counter;
   // measurements begin with the second pulse. Strobes default low so they
   // last exactly one cycle.
   always_comb begin
      gap_cnt_d   = gap_cnt_q;
      period_d    = period_q;
      match_cnt_d = match_cnt_q;
      locked_d    = locked_q;
      valid_d     = 1'b0;
      mismatch_d  = 1'b0;
      timeout_d   = 1'b0;
      case (state_q)
         IDLE: begin
            gap_cnt_d = '0;
         end
         ARMED, TRACK: begin
            if (pulse_in) begin
               gap_cnt_d = '0;
               valid_d   = 1'b1;
               if (state_q == TRACK && gap_cnt_q == period_q) begin
                  match_cnt_d = match_inc;
                  locked_d    = locked_q | (match_inc >= LOCK_MAX);
               end else begin
                  mismatch_d  = (state_q == TRACK);
                  period_d    = gap_cnt_q;
                  match_cnt_d = MATCH_ONE;
                  locked_d    = LOCK_ON_FIRST;
               end
            end else if (gap_full) begin
               timeout_d   = 1'b1;
               locked_d    = 1'b0;
               period_d    = '0;
               match_cnt_d = '0;
               gap_cnt_d   = '0;
            end else begin
               gap_cnt_d = gap_cnt_q + 1'b1;
            end
         end
         default: begin
            gap_cnt_d = '0;
         end
      endcase
   end

   // Datapath and output registers; reset clears everything.
   always_ff @(posedge clk) begin
      if (rst) begin
         gap_cnt_q   <= '0;
         period_q    <= '0;
         match_cnt_q <= '0;
         valid_q     <= 1'b0;
         locked_q    <= 1'b0;
         mismatch_q  <= 1'b0;
         timeout_q   <= 1'b0;
      end else begin
         gap_cnt_q   <= gap_cnt_d;
         period_q    <= period_d;
         match_cnt_q <= match_cnt_d;
         valid_q     <= valid_d;
         locked_q    <= locked_d;
         mismatch_q  <= mismatch_d;
         timeout_q   <= timeout_d;
      end
   end

   assign period_out   = period_q;
   assign period_valid = valid_q;
   assign locked       = locked_q;
   assign mismatch     = mismatch_q;
   assign timeout      = timeout_q;

endmodule

// File: tb/tb_pulse_period_meter.sv
// ---------------------------------------------------------------------------
// tb_pulse_period_meter
//
// Directed bench for pulse_period_meter. Two instances share the stimulus:
// dut0 with LOCK_COUNT=3 and dut1 with LOCK_COUNT=1. Outputs are compared as
// a packed vector {period_out, period_valid, locked, mismatch, timeout}.
// ---------------------------------------------------------------------------
module tb_pulse_period_meter;

   localparam int WIDTH = 4;

   logic             clk;
   logic             rst;
   logic             pulse_in;
   logic [WIDTH-1:0] period0, period1;
   logic             valid0, valid1;
   logic             locked0, locked1;
   logic             mism0, mism1;
   logic             tout0, tout1;

   int checks = 0;
   int errors = 0;

   typedef struct {
      logic       pulse;
      logic [7:0] exp0;
      logic [7:0] exp1;
   } vec_t;

   vec_t vecs [14];

   pulse_period_meter #(.WIDTH(WIDTH), .LOCK_COUNT(3)) dut0 (
      .clk          (clk),
      .rst          (rst),
      .pulse_in     (pulse_in),
      .period_out   (period0),
      .period_valid (valid0),
      .locked       (locked0),
      .mismatch     (mism0),
      .timeout      (tout0)
   );

   pulse_period_meter #(.WIDTH(WIDTH), .LOCK_COUNT(1)) dut1 (
      .clk          (clk),
      .rst          (rst),
      .pulse_in     (pulse_in),
      .period_out   (period1),
      .period_valid (valid1),
      .locked       (locked1),
      .mismatch     (mism1),
      .timeout      (tout1)
   );

   // Free-running clock, period 10.
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Safety net so the run always ends.
   initial begin
      #200000;
      $display("[TB] FAIL watchdog expired");
      $fatal(1, "[TB] watchdog");
   end

   function automatic logic [7:0] mk(input logic [3:0] p, input logic v,
                                     input logic l, input logic m, input logic t);
      return {p, v, l, m, t};
   endfunction

   function automatic logic [7:0] obs0();
      return {period0, valid0, locked0, mism0, tout0};
   endfunction

   function automatic logic [7:0] obs1();
      return {period1, valid1, locked1, mism1, tout1};
   endfunction

   // Drive one cycle of inputs and sample just after the rising edge.
   task automatic applyStimulus(input logic r, input logic p);
      rst      = r;
      pulse_in = p;
      @(posedge clk);
      #1;
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) applyStimulus(1'b0, 1'b0);
   endtask

   task automatic checkOutput(input string name, input logic [7:0] act, input logic [7:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("[TB] FAIL %s: got period=%0d valid=%b locked=%b mismatch=%b timeout=%b, want period=%0d valid=%b locked=%b mismatch=%b timeout=%b",
                  name, act[7:4], act[3], act[2], act[1], act[0],
                  exp[7:4], exp[3], exp[2], exp[1], exp[0]);
      end
   endtask

   task automatic doReset();
      applyStimulus(1'b1, 1'b0);
      rst = 1'b0;
   endtask

   initial begin
      rst      = 1'b1;
      pulse_in = 1'b0;

      // Constant-high train, then irregular gaps producing mismatches.
      vecs[0]  = '{1'b1, mk(0,0,0,0,0), mk(0,0,0,0,0)};
      vecs[1]  = '{1'b1, mk(0,1,0,0,0), mk(0,1,1,0,0)};
      vecs[2]  = '{1'b1, mk(0,1,0,0,0), mk(0,1,1,0,0)};
      vecs[3]  = '{1'b1, mk(0,1,1,0,0), mk(0,1,1,0,0)};
      vecs[4]  = '{1'b1, mk(0,1,1,0,0), mk(0,1,1,0,0)};
      vecs[5]  = '{1'b0, mk(0,0,1,0,0), mk(0,0,1,0,0)};
      vecs[6]  = '{1'b0, mk(0,0,1,0,0), mk(0,0,1,0,0)};
      vecs[7]  = '{1'b1, mk(2,1,0,1,0), mk(2,1,1,1,0)};
      vecs[8]  = '{1'b0, mk(2,0,0,0,0), mk(2,0,1,0,0)};
      vecs[9]  = '{1'b1, mk(1,1,0,1,0), mk(1,1,1,1,0)};
      vecs[10] = '{1'b0, mk(1,0,0,0,0), mk(1,0,1,0,0)};
      vecs[11] = '{1'b1, mk(1,1,0,0,0), mk(1,1,1,0,0)};
      vecs[12] = '{1'b0, mk(1,0,0,0,0), mk(1,0,1,0,0)};
      vecs[13] = '{1'b1, mk(1,1,1,0,0), mk(1,1,1,0,0)};

      doReset();
      checkOutput("reset0", obs0(), mk(0,0,0,0,0));
      checkOutput("reset1", obs1(), mk(0,0,0,0,0));

      for (int i = 0; i < 14; i++) begin
         applyStimulus(1'b0, vecs[i].pulse);
         checkOutput($sformatf("vec%0d_lc3", i), obs0(), vecs[i].exp0);
         checkOutput($sformatf("vec%0d_lc1", i), obs1(), vecs[i].exp1);
      end

      // Period 5 (every 6 cycles), lock, then switch to period 3.
      doReset();
      applyStimulus(1'b0, 1'b1);
      checkOutput("p5_arm", obs0(), mk(0,0,0,0,0));
      idle(5);
      applyStimulus(1'b0, 1'b1);
      checkOutput("p5_pulse2", obs0(), mk(5,1,0,0,0));
      checkOutput("p5_pulse2_lc1", obs1(), mk(5,1,1,0,0));
      idle(1);
      checkOutput("p5_strobe_drop", obs0(), mk(5,0,0,0,0));
      idle(4);
      applyStimulus(1'b0, 1'b1);
      checkOutput("p5_pulse3", obs0(), mk(5,1,0,0,0));
      idle(5);
      applyStimulus(1'b0, 1'b1);
      checkOutput("p5_pulse4_lock", obs0(), mk(5,1,1,0,0));
      idle(5);
      applyStimulus(1'b0, 1'b1);
      checkOutput("p5_pulse5", obs0(), mk(5,1,1,0,0));
      idle(3);
      checkOutput("p5_hold_locked", obs0(), mk(5,0,1,0,0));
      applyStimulus(1'b0, 1'b1);
      checkOutput("p3_mismatch", obs0(), mk(3,1,0,1,0));
      checkOutput("p3_mismatch_lc1", obs1(), mk(3,1,1,1,0));
      idle(1);
      checkOutput("p3_mismatch_drop", obs0(), mk(3,0,0,0,0));
      idle(2);
      applyStimulus(1'b0, 1'b1);
      checkOutput("p3_match2", obs0(), mk(3,1,0,0,0));
      idle(3);
      applyStimulus(1'b0, 1'b1);
      checkOutput("p3_relock", obs0(), mk(3,1,1,0,0));

      // Period 15: pulse coincides with all-ones gap, lock, then timeout.
      doReset();
      applyStimulus(1'b0, 1'b1);
      idle(15);
      checkOutput("p15_gap_full_no_tout", obs0(), mk(0,0,0,0,0));
      applyStimulus(1'b0, 1'b1);
      checkOutput("p15_meas1", obs0(), mk(15,1,0,0,0));
      idle(15);
      applyStimulus(1'b0, 1'b1);
      checkOutput("p15_meas2", obs0(), mk(15,1,0,0,0));
      idle(15);
      applyStimulus(1'b0, 1'b1);
      checkOutput("p15_lock", obs0(), mk(15,1,1,0,0));
      idle(15);
      checkOutput("p15_pre_timeout", obs0(), mk(15,0,1,0,0));
      idle(1);
      checkOutput("timeout_strobe", obs0(), mk(0,0,0,0,1));
      checkOutput("timeout_strobe_lc1", obs1(), mk(0,0,0,0,1));
      idle(1);
      checkOutput("timeout_drop", obs0(), mk(0,0,0,0,0));
      applyStimulus(1'b0, 1'b1);
      checkOutput("rearm_no_valid", obs0(), mk(0,0,0,0,0));
      idle(2);
      applyStimulus(1'b0, 1'b1);
      checkOutput("rearm_meas", obs0(), mk(2,1,0,0,0));

      // Reset while locked with pulse_in high in the reset cycle.
      doReset();
      for (int i = 0; i < 5; i++) applyStimulus(1'b0, 1'b1);
      checkOutput("hi_locked", obs0(), mk(0,1,1,0,0));
      applyStimulus(1'b1, 1'b1);
      checkOutput("rst_mid_lock", obs0(), mk(0,0,0,0,0));
      checkOutput("rst_mid_lock_lc1", obs1(), mk(0,0,0,0,0));
      applyStimulus(1'b0, 1'b1);
      checkOutput("post_rst_arm", obs0(), mk(0,0,0,0,0));
      applyStimulus(1'b0, 1'b1);
      checkOutput("post_rst_meas", obs0(), mk(0,1,0,0,0));

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
